exe_stage_hs: RTL and testbench

//  Parametrised execute stage with valid/ready handshakes on both sides; sits between decode and memory stage.

---
 rtl/exe_stage_hs.sv | 224 ++++++++++++++++++++++
 tb/tb_exe_stage_hs.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage_hs.sv
`default_nettype none
// ----------------------------------------------------------------------------
// exe_stage_hs : execute stage with valid/ready handshakes, multi-cycle op
// sequencing and an EX/MEM output register. Optional macro: EXE_FWD_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module exe_stage_hs #(
  parameter int DATA_W   = 32,
  parameter int RADDR_W  = 5,
  parameter int ALU_OP_W = 5,
  parameter int BE_W     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                e_valid_i,
  output logic                e_ready_o,
  input  logic [ALU_OP_W-1:0] e_alu_op_i,
  input  logic [DATA_W-1:0]   e_rs1_i,
  input  logic [DATA_W-1:0]   e_rs2_i,
  input  logic [DATA_W-1:0]   e_imm_i,
  input  logic [RADDR_W-1:0]  e_raddr_rs1_i,
  input  logic [RADDR_W-1:0]  e_raddr_rs2_i,
  input  logic [1:0]          e_origin_i,
  input  logic [1:0]          e_target_i,
  input  logic [DATA_W-1:0]   e_pc4_i,
  input  logic [DATA_W-1:0]   e_brj_pc_i,
  input  logic [RADDR_W-1:0]  e_waddr_i,
  input  logic                e_wr_i,
  input  logic [1:0]          e_store_op_i,
  input  logic [2:0]          e_load_op_i,
  input  logic                e_data_wr_i,
  input  logic                e_data_rd_i,
  input  logic [BE_W-1:0]     e_be_i,
  output logic [DATA_W-1:0]   alu_s1_o,
  output logic [DATA_W-1:0]   alu_s2_o,
  input  logic [DATA_W-1:0]   alu_res_i,
  output logic                mc_start_o,
  input  logic                mc_done_i,
  input  logic [DATA_W-1:0]   mc_res_i,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic [DATA_W-1:0]   m_rd_o,
  output logic [DATA_W-1:0]   m_addr_o,
  output logic [RADDR_W-1:0]  m_waddr_o,
  output logic                m_wr_o,
  output logic                m_data_wr_o,
  output logic                m_data_rd_o,
  output logic [BE_W-1:0]     m_be_o,
  output logic [2:0]          m_load_op_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MC_WAIT = 2'd1,
    MC_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0]  mc_res_q, mc_res_d;
  logic               m_valid_q, m_valid_d;
  logic [DATA_W-1:0]  m_rd_q, m_rd_d;
  logic [DATA_W-1:0]  m_addr_q, m_addr_d;
  logic [RADDR_W-1:0] m_waddr_q, m_waddr_d;
  logic               m_wr_q, m_wr_d;
  logic               m_data_wr_q, m_data_wr_d;
  logic               m_data_rd_q, m_data_rd_d;
  logic [BE_W-1:0]    m_be_q, m_be_d;
  logic [2:0]         m_load_op_q, m_load_op_d;

  logic [DATA_W-1:0]  rs1_f;
  logic [DATA_W-1:0]  rs2_f;
  logic [DATA_W-1:0]  result;
  logic [DATA_W-1:0]  store_data;
  logic [DATA_W-1:0]  rd_val;
  logic               out_free;
  logic               is_mc;
  logic               load;

`ifdef EXE_FWD_EN
  // Loads are excluded: their rd value is not known until the memory stage.
  logic fwd_ok;
  assign fwd_ok = m_valid_q & m_wr_q & ~m_data_rd_q & (m_waddr_q != '0);
  assign rs1_f  = (fwd_ok && (m_waddr_q == e_raddr_rs1_i)) ? m_rd_q : e_rs1_i;
  assign rs2_f  = (fwd_ok && (m_waddr_q == e_raddr_rs2_i)) ? m_rd_q : e_rs2_i;
  logic [ALU_OP_W-2:0] unused_op;
  assign unused_op = e_alu_op_i[ALU_OP_W-2:0];
`else
  assign rs1_f = e_rs1_i;
  assign rs2_f = e_rs2_i;
  logic unused_sigs;
  assign unused_sigs = ^{e_raddr_rs1_i, e_raddr_rs2_i, e_alu_op_i[ALU_OP_W-2:0]};
`endif

  assign alu_s1_o = rs1_f;
  assign alu_s2_o = e_origin_i[0] ? e_imm_i : rs2_f;
  assign out_free = ~m_valid_q | m_ready_i;
  assign is_mc    = e_alu_op_i[ALU_OP_W-1];
  assign result   = (state_q == MC_DONE) ? mc_res_q : alu_res_i;

  always_comb begin
    store_data = '0;
    case (e_store_op_i)
      2'd0:    store_data = DATA_W'(rs2_f[7:0]);
      2'd1:    store_data = DATA_W'(rs2_f[15:0]);
      2'd2:    store_data = DATA_W'(rs2_f[31:0]);
      default: store_data = '0;
    endcase
  end

  always_comb begin
    rd_val = '0;
    case (e_target_i)
      2'd0:    rd_val = result;
      2'd1:    rd_val = store_data;
      2'd2:    rd_val = '0;
      default: rd_val = e_origin_i[1] ? e_pc4_i : e_brj_pc_i;
    endcase
  end

  // Sequencer: start pulse only from IDLE; the op is held upstream until MC_DONE.
  always_comb begin
    state_d    = state_q;
    mc_res_d   = mc_res_q;
    e_ready_o  = 1'b0;
    mc_start_o = 1'b0;
    load       = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_mc) begin
            mc_start_o = e_valid_i;
            if (e_valid_i) state_d = MC_WAIT;
          end else begin
            e_ready_o = out_free;
            load      = e_valid_i & out_free;
          end
        end
        MC_WAIT: begin
          if (mc_done_i) begin
            mc_res_d = mc_res_i;
            state_d  = MC_DONE;
          end
        end
        MC_DONE: begin
          e_ready_o = out_free;
          load      = e_valid_i & out_free;
          if (load) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    m_valid_d   = m_valid_q;
    m_rd_d      = m_rd_q;
    m_addr_d    = m_addr_q;
    m_waddr_d   = m_waddr_q;
    m_wr_d      = m_wr_q;
    m_data_wr_d = m_data_wr_q;
    m_data_rd_d = m_data_rd_q;
    m_be_d      = m_be_q;
    m_load_op_d = m_load_op_q;
    if (flush_i) begin
      m_valid_d = 1'b0;
    end else if (load) begin
      m_valid_d   = 1'b1;
      m_rd_d      = rd_val;
      m_addr_d    = result;
      m_waddr_d   = e_waddr_i;
      m_wr_d      = e_wr_i;
      m_data_wr_d = e_data_wr_i;
      m_data_rd_d = e_data_rd_i;
      m_be_d      = e_be_i;
      m_load_op_d = e_load_op_i;
    end else if (m_ready_i) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mc_res_q    <= '0;
      m_valid_q   <= 1'b0;
      m_rd_q      <= '0;
      m_addr_q    <= '0;
      m_waddr_q   <= '0;
      m_wr_q      <= 1'b0;
      m_data_wr_q <= 1'b0;
      m_data_rd_q <= 1'b0;
      m_be_q      <= '0;
      m_load_op_q <= '0;
    end else begin
      state_q     <= state_d;
      mc_res_q    <= mc_res_d;
      m_valid_q   <= m_valid_d;
      m_rd_q      <= m_rd_d;
      m_addr_q    <= m_addr_d;
      m_waddr_q   <= m_waddr_d;
      m_wr_q      <= m_wr_d;
      m_data_wr_q <= m_data_wr_d;
      m_data_rd_q <= m_data_rd_d;
      m_be_q      <= m_be_d;
      m_load_op_q <= m_load_op_d;
    end
  end

  assign m_valid_o   = m_valid_q;
  assign m_rd_o      = m_rd_q;
  assign m_addr_o    = m_addr_q;
  assign m_waddr_o   = m_waddr_q;
  assign m_wr_o      = m_wr_q;
  assign m_data_wr_o = m_data_wr_q;
  assign m_data_rd_o = m_data_rd_q;
  assign m_be_o      = m_be_q;
  assign m_load_op_o = m_load_op_q;

endmodule
`default_nettype wire

// File: tb/tb_exe_stage_hs.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_exe_stage_hs : directed self-checking bench for exe_stage_hs.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_exe_stage_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        e_valid_i;
  logic        e_ready_o;
  logic [4:0]  e_alu_op_i;
  logic [31:0] e_rs1_i, e_rs2_i, e_imm_i;
  logic [4:0]  e_raddr_rs1_i, e_raddr_rs2_i;
  logic [1:0]  e_origin_i, e_target_i;
  logic [31:0] e_pc4_i, e_brj_pc_i;
  logic [4:0]  e_waddr_i;
  logic        e_wr_i;
  logic [1:0]  e_store_op_i;
  logic [2:0]  e_load_op_i;
  logic        e_data_wr_i, e_data_rd_i;
  logic [3:0]  e_be_i;
  logic [31:0] alu_s1_o, alu_s2_o, alu_res_i;
  logic        mc_start_o, mc_done_i;
  logic [31:0] mc_res_i;
  logic        m_valid_o, m_ready_i;
  logic [31:0] m_rd_o, m_addr_o;
  logic [4:0]  m_waddr_o;
  logic        m_wr_o, m_data_wr_o, m_data_rd_o;
  logic [3:0]  m_be_o;
  logic [2:0]  m_load_op_o;

  int vectors    = 0;
  int miscompares = 0;
  int start_cnt  = 0;

  always #5 clk = ~clk;

  // External single-cycle ALU: an adder is enough for these vectors.
  assign alu_res_i = alu_s1_o + alu_s2_o;

  always @(negedge clk) if (mc_start_o) start_cnt++;

  exe_stage_hs dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .e_valid_i(e_valid_i), .e_ready_o(e_ready_o), .e_alu_op_i(e_alu_op_i),
    .e_rs1_i(e_rs1_i), .e_rs2_i(e_rs2_i), .e_imm_i(e_imm_i),
    .e_raddr_rs1_i(e_raddr_rs1_i), .e_raddr_rs2_i(e_raddr_rs2_i),
    .e_origin_i(e_origin_i), .e_target_i(e_target_i),
    .e_pc4_i(e_pc4_i), .e_brj_pc_i(e_brj_pc_i),
    .e_waddr_i(e_waddr_i), .e_wr_i(e_wr_i), .e_store_op_i(e_store_op_i),
    .e_load_op_i(e_load_op_i), .e_data_wr_i(e_data_wr_i), .e_data_rd_i(e_data_rd_i),
    .e_be_i(e_be_i), .alu_s1_o(alu_s1_o), .alu_s2_o(alu_s2_o), .alu_res_i(alu_res_i),
    .mc_start_o(mc_start_o), .mc_done_i(mc_done_i), .mc_res_i(mc_res_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_rd_o(m_rd_o), .m_addr_o(m_addr_o),
    .m_waddr_o(m_waddr_o), .m_wr_o(m_wr_o), .m_data_wr_o(m_data_wr_o),
    .m_data_rd_o(m_data_rd_o), .m_be_o(m_be_o), .m_load_op_o(m_load_op_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [4:0] aop, input logic [31:0] rs1, input logic [31:0] rs2,
                    input logic [1:0] target, input logic [4:0] waddr);
    e_valid_i    = 1'b1;
    e_alu_op_i   = aop;
    e_rs1_i      = rs1;
    e_rs2_i      = rs2;
    e_origin_i   = 2'b00;
    e_target_i   = target;
    e_waddr_i    = waddr;
    e_wr_i       = 1'b1;
    e_data_wr_i  = 1'b0;
    e_data_rd_i  = 1'b0;
    e_raddr_rs1_i = '0;
    e_raddr_rs2_i = '0;
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; e_valid_i = 1'b0; e_alu_op_i = '0;
    e_rs1_i = '0; e_rs2_i = '0; e_imm_i = '0; e_raddr_rs1_i = '0; e_raddr_rs2_i = '0;
    e_origin_i = '0; e_target_i = '0; e_pc4_i = '0; e_brj_pc_i = '0; e_waddr_i = '0;
    e_wr_i = 1'b0; e_store_op_i = '0; e_load_op_i = '0; e_data_wr_i = 1'b0;
    e_data_rd_i = 1'b0; e_be_i = '0; mc_done_i = 1'b0; mc_res_i = '0; m_ready_i = 1'b1;
    tick(); tick();
    chk("rst_m_valid", 32'(m_valid_o), 32'd0);
    chk("rst_m_rd", m_rd_o, 32'd0);
    chk("rst_mc_start", 32'(mc_start_o), 32'd0);
    rst = 1'b0;
    tick();

    // ADD 5+7
    op(5'd0, 32'd5, 32'd7, 2'd0, 5'd1);
    #1;
    chk("add_ready", 32'(e_ready_o), 32'd1);
    tick();
    e_valid_i = 1'b0;
    chk("add_valid", 32'(m_valid_o), 32'd1);
    chk("add_rd", m_rd_o, 32'd12);
    chk("add_addr", m_addr_o, 32'd12);
    chk("add_waddr", 32'(m_waddr_o), 32'd1);

    // SB then SH, back-to-back, address from imm
    op(5'd0, 32'h1000, 32'h12345678, 2'd1, 5'd0);
    e_origin_i = 2'b01; e_imm_i = 32'h10; e_store_op_i = 2'd0;
    e_wr_i = 1'b0; e_data_wr_i = 1'b1; e_be_i = 4'b0001;
    tick();
    chk("sb_rd", m_rd_o, 32'h00000078);
    chk("sb_addr", m_addr_o, 32'h1010);
    chk("sb_data_wr", 32'(m_data_wr_o), 32'd1);
    chk("sb_be", 32'(m_be_o), 32'h1);
    e_store_op_i = 2'd1; e_be_i = 4'b0011;
    tick();
    chk("sh_rd", m_rd_o, 32'h00005678);
    e_store_op_i = 2'd2;
    tick();
    chk("sw_rd", m_rd_o, 32'h12345678);

    // pc targets and zero target
    op(5'd0, 32'd0, 32'd0, 2'd3, 5'd2);
    e_origin_i = 2'b10; e_pc4_i = 32'h104; e_brj_pc_i = 32'h200;
    tick();
    chk("pc4_rd", m_rd_o, 32'h104);
    e_origin_i = 2'b00;
    tick();
    chk("brj_rd", m_rd_o, 32'h200);
    e_target_i = 2'd2;
    tick();
    chk("zero_rd", m_rd_o, 32'd0);
    e_valid_i = 1'b0;
    tick();
    chk("drain_valid", 32'(m_valid_o), 32'd0);

    // Back-pressure: A loads, B waits three cycles, then accept+reload
    m_ready_i = 1'b0;
    op(5'd0, 32'd1, 32'd2, 2'd0, 5'd3);
    tick();
    chk("bp_a_rd", m_rd_o, 32'd3);
    op(5'd0, 32'd10, 32'd20, 2'd0, 5'd4);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready_low", 32'(e_ready_o), 32'd0);
      tick();
      chk("bp_hold_valid", 32'(m_valid_o), 32'd1);
      chk("bp_hold_rd", m_rd_o, 32'd3);
      chk("bp_hold_waddr", 32'(m_waddr_o), 32'd3);
    end
    m_ready_i = 1'b1;
    #1;
    chk("bp_ready_high", 32'(e_ready_o), 32'd1);
    tick();
    e_valid_i = 1'b0;
    chk("bp_b_valid", 32'(m_valid_o), 32'd1);
    chk("bp_b_rd", m_rd_o, 32'd30);
    chk("bp_b_waddr", 32'(m_waddr_o), 32'd4);
    tick();
    chk("bp_drained", 32'(m_valid_o), 32'd0);

    // MUL 6*7, done 4 cycles after start
    op(5'b10000, 32'd6, 32'd7, 2'd0, 5'd7);
    #1;
    chk("mul_start", 32'(mc_start_o), 32'd1);
    chk("mul_ready0", 32'(e_ready_o), 32'd0);
    tick();
    chk("mul_start_once", 32'(mc_start_o), 32'd0);
    chk("mul_s1", alu_s1_o, 32'd6);
    tick(); tick(); tick();
    mc_done_i = 1'b1; mc_res_i = 32'd42;
    tick();
    mc_done_i = 1'b0; mc_res_i = 32'hDEAD;
    chk("mul_no_valid_yet", 32'(m_valid_o), 32'd0);
    chk("mul_ready_done", 32'(e_ready_o), 32'd1);
    tick();
    e_valid_i = 1'b0;
    chk("mul_valid", 32'(m_valid_o), 32'd1);
    chk("mul_rd", m_rd_o, 32'd42);
    chk("mul_addr", m_addr_o, 32'd42);
    chk("mul_start_cnt", 32'(start_cnt), 32'd1);
    tick();

    // Flush during MC_WAIT, late done ignored
    op(5'b10000, 32'd3, 32'd3, 2'd0, 5'd8);
    tick();
    tick();
    flush_i = 1'b1;
    #1;
    chk("flush_ready", 32'(e_ready_o), 32'd0);
    chk("flush_start", 32'(mc_start_o), 32'd0);
    tick();
    flush_i = 1'b0; e_valid_i = 1'b0;
    tick();
    mc_done_i = 1'b1; mc_res_i = 32'd9;
    tick();
    mc_done_i = 1'b0;
    tick();
    chk("flush_no_valid", 32'(m_valid_o), 32'd0);
    op(5'd0, 32'd2, 32'd3, 2'd0, 5'd9);
    #1;
    chk("flush_next_ready", 32'(e_ready_o), 32'd1);
    tick();
    e_valid_i = 1'b0;
    chk("flush_next_rd", m_rd_o, 32'd5);
    chk("flush_start_cnt", 32'(start_cnt), 32'd2);

    // Back-to-back dependency on x5
    op(5'd0, 32'd10, 32'd0, 2'd0, 5'd5);
    tick();
    op(5'd0, 32'd0, 32'd1, 2'd0, 5'd6);
    e_raddr_rs1_i = 5'd5;
    tick();
    e_valid_i = 1'b0;
`ifdef EXE_FWD_EN
    chk("fwd_rd", m_rd_o, 32'd11);
`else
    chk("fwd_rd", m_rd_o, 32'd1);
`endif
    tick();

    // Async reset mid multi-cycle op
    op(5'b10000, 32'd4, 32'd4, 2'd0, 5'd10);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(m_valid_o), 32'd0);
    chk("arst_idle_start", 32'(mc_start_o), 32'd1);
    e_valid_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("arst_m_rd", m_rd_o, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
